// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage forwarding / hazard unit: operand select
// codes, the pipeline-control state enum and the select priority helper.
package hazard_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_BYP = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_e;

  // Youngest producer wins: EX/MEM result, then MEM/WB, then the write in flight.
  function automatic logic [1:0] pick_sel(input logic ex_hit,
                                          input logic mem_hit,
                                          input logic wb_hit);
    if (ex_hit)       return SEL_ALU;
    else if (mem_hit) return SEL_WB;
    else if (wb_hit)  return SEL_BYP;
    else              return SEL_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline <-> hazard unit bundle. Counter signals exist only when
// HAZARD_PERF_CNT_EN is defined.
interface hazard_forward_unit_if #(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);

  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [REG_AW-1:0]           ex_rdst;
  logic [REG_AW-1:0]           mem_rdst;
  logic [REG_AW-1:0]           wb_rdst;
  logic                        ex_wb;
  logic                        mem_wb;
  logic                        wb_wb;
  logic                        ex_mem_read;
  logic                        mem_busy;
  logic [2*NUM_SRC-1:0]        exec_sel;
  logic                        stall_if_id;
  logic                        bubble_ex;
  logic                        freeze;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]            lu_stall_cnt;
  logic [CNT_W-1:0]            mem_stall_cnt;
`endif

  if (NUM_SRC < 1 || NUM_SRC > 4 || REG_AW < 1 || CNT_W < 1) begin : g_cfg_check
    $error("hazard_forward_unit_if: unsupported parameter set");
  end

  modport master (
    output id_valid, id_src, id_src_used,
    output ex_rdst, mem_rdst, wb_rdst,
    output ex_wb, mem_wb, wb_wb, ex_mem_read, mem_busy,
    input  exec_sel, stall_if_id, bubble_ex, freeze
`ifdef HAZARD_PERF_CNT_EN
    , input lu_stall_cnt, mem_stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_src, id_src_used,
    input  ex_rdst, mem_rdst, wb_rdst,
    input  ex_wb, mem_wb, wb_wb, ex_mem_read, mem_busy,
    output exec_sel, stall_if_id, bubble_ex, freeze
`ifdef HAZARD_PERF_CNT_EN
    , output lu_stall_cnt, mem_stall_cnt
`endif
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_match.sv
// Per-operand priority comparator: forwarding select plus load-use hit for one
// ID source register. Purely combinational.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [REG_AW-1:0] ex_rdst,
  input  logic              ex_wb,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rdst,
  input  logic              mem_wb,
  input  logic [REG_AW-1:0] wb_rdst,
  input  logic              wb_wb,
  output logic [1:0]        sel,
  output logic              lu_hit
);

  logic ex_match;

  // A load in EX has no result yet, so it can only stall, never forward.
  assign ex_match = used & ex_wb & (src == ex_rdst);
  assign lu_hit   = ex_match & ex_mem_read;
  assign sel      = pick_sel(ex_match & ~ex_mem_read,
                             mem_wb & (src == mem_rdst),
                             wb_wb & (src == wb_rdst));

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage operand forwarding with registered EX selects, load-use bubble and
// mem_busy freeze control. Define HAZARD_PERF_CNT_EN to add stall counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave bus
);

  logic [2*NUM_SRC-1:0] id_sel;
  logic [NUM_SRC-1:0]   src_hit;
  logic                 lu_hit;
  logic                 freeze;
  logic                 bubble_ex;
  logic                 stall_if_id;
  logic [2*NUM_SRC-1:0] exec_sel_q;
  hazard_state_e        state_q;

  if (NUM_SRC < 1 || NUM_SRC > 4 || REG_AW < 1 || CNT_W < 1) begin : g_cfg_check
    $error("hazard_forward_unit: unsupported parameter set");
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(.REG_AW(REG_AW)) u_match (
      .src         (bus.id_src[i*REG_AW +: REG_AW]),
      .used        (bus.id_src_used[i]),
      .ex_rdst     (bus.ex_rdst),
      .ex_wb       (bus.ex_wb),
      .ex_mem_read (bus.ex_mem_read),
      .mem_rdst    (bus.mem_rdst),
      .mem_wb      (bus.mem_wb),
      .wb_rdst     (bus.wb_rdst),
      .wb_wb       (bus.wb_wb),
      .sel         (id_sel[2*i +: 2]),
      .lu_hit      (src_hit[i])
    );
  end

  assign lu_hit = bus.id_valid & (|src_hit);

  // A bubble is only legal from RUN; mem_busy overrides everything but reset.
  always_comb begin
    freeze      = ~rst & bus.mem_busy;
    bubble_ex   = ~rst & ~bus.mem_busy & (state_q == RUN) & lu_hit;
    stall_if_id = ~rst & (bus.mem_busy | ((state_q == RUN) & lu_hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.mem_busy)  state_q <= MEM_WAIT;
          else if (lu_hit)   state_q <= LU_STALL;
        end
        LU_STALL: state_q <= bus.mem_busy ? MEM_WAIT : RUN;
        MEM_WAIT: begin
          if (!bus.mem_busy) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            exec_sel_q <= '0;
    else if (freeze)    exec_sel_q <= exec_sel_q;
    else if (bubble_ex) exec_sel_q <= '0;
    else                exec_sel_q <= id_sel;
  end

  assign bus.exec_sel    = exec_sel_q;
  assign bus.stall_if_id = stall_if_id;
  assign bus.bubble_ex   = bubble_ex;
  assign bus.freeze      = freeze;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] mem_cnt_q;

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (bubble_ex && (lu_cnt_q != '1)) lu_cnt_q  <= lu_cnt_q + CNT_W'(1);
      if (freeze && (mem_cnt_q != '1))   mem_cnt_q <= mem_cnt_q + CNT_W'(1);
    end
  end

  assign bus.lu_stall_cnt  = lu_cnt_q;
  assign bus.mem_stall_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector table followed by random
// traffic scored against a behavioural model of the forwarding/stall rules.
module tb_hazard_forward_unit;

  localparam int REG_AW  = 3;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 16;

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [1:0]  used;
    logic [2:0]  exr;
    logic        exw;
    logic        exmr;
    logic [2:0]  memr;
    logic        memw;
    logic [2:0]  wbr;
    logic        wbw;
    logic        busy;
    logic        stall;
    logic        bubble;
    logic        frz;
    logic [3:0]  sel;
    logic [15:0] lu;
    logic [15:0] mc;
  } vec_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  hazard_forward_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

  hazard_forward_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what EX will see next, whether last cycle froze or bubbled,
  // and the running event counts since the last reset.
  logic [3:0] m_sel;
  bit         m_prev_frz;
  bit         m_prev_bub;
  int         m_lu;
  int         m_mc;

  function automatic vec_t mk(string name, logic r, logic valid, logic [2:0] s0, logic [2:0] s1,
                              logic [1:0] used, logic [2:0] exr, logic exw, logic exmr,
                              logic [2:0] memr, logic memw, logic [2:0] wbr, logic wbw,
                              logic busy, logic stall, logic bubble, logic frz,
                              logic [3:0] sel, logic [15:0] lu, logic [15:0] mc);
    vec_t v;
    v.name = name; v.rst = r; v.valid = valid; v.s0 = s0; v.s1 = s1; v.used = used;
    v.exr = exr; v.exw = exw; v.exmr = exmr; v.memr = memr; v.memw = memw;
    v.wbr = wbr; v.wbw = wbw; v.busy = busy; v.stall = stall; v.bubble = bubble;
    v.frz = frz; v.sel = sel; v.lu = lu; v.mc = mc;
    return v;
  endfunction

  function automatic logic [1:0] ref_sel(input vec_t v, input logic [2:0] src, input logic used);
    if (used && v.exw && src == v.exr && !v.exmr) return 2'b01;
    if (v.memw && src == v.memr)                  return 2'b10;
    if (v.wbw && src == v.wbr)                    return 2'b11;
    return 2'b00;
  endfunction

  // A load-use bubble can only be inserted when the previous cycle neither
  // bubbled nor froze; mem_busy always freezes and stalls.
  function automatic vec_t model_expect(input vec_t v);
    vec_t e;
    bit   hazard;
    bit   can_bubble;
    e = v;
    hazard     = v.valid && v.exmr && v.exw &&
                 ((v.used[0] && v.s0 == v.exr) || (v.used[1] && v.s1 == v.exr));
    can_bubble = !m_prev_frz && !m_prev_bub;
    if (v.rst) begin
      e.stall = 0; e.bubble = 0; e.frz = 0;
    end else begin
      e.frz    = v.busy;
      e.bubble = !v.busy && can_bubble && hazard;
      e.stall  = v.busy || (can_bubble && hazard);
    end
    e.sel = m_sel;
    e.lu  = 16'(m_lu);
    e.mc  = 16'(m_mc);
    return e;
  endfunction

  task automatic model_advance(input vec_t v, input vec_t e);
    if (v.rst) begin
      m_sel = '0; m_prev_frz = 0; m_prev_bub = 0; m_lu = 0; m_mc = 0;
    end else begin
      m_prev_frz = e.frz;
      m_prev_bub = e.bubble;
      if (e.frz)         m_sel = m_sel;
      else if (e.bubble) m_sel = '0;
      else               m_sel = {ref_sel(v, v.s1, v.used[1]), ref_sel(v, v.s0, v.used[0])};
      if (e.bubble && m_lu < 65535) m_lu++;
      if (e.frz && m_mc < 65535)    m_mc++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    bus.id_valid       = v.valid;
    bus.id_src         = {v.s1, v.s0};
    bus.id_src_used    = v.used;
    bus.ex_rdst        = v.exr;
    bus.ex_wb          = v.exw;
    bus.ex_mem_read    = v.exmr;
    bus.mem_rdst       = v.memr;
    bus.mem_wb         = v.memw;
    bus.wb_rdst        = v.wbr;
    bus.wb_wb          = v.wbw;
    bus.mem_busy       = v.busy;
  endtask

  task automatic checkValue(input string tag, input string what,
                            input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h", tag, what, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t e);
    checkValue(tag, "stall_if_id", {15'b0, bus.stall_if_id}, {15'b0, e.stall});
    checkValue(tag, "bubble_ex",   {15'b0, bus.bubble_ex},   {15'b0, e.bubble});
    checkValue(tag, "freeze",      {15'b0, bus.freeze},      {15'b0, e.frz});
    checkValue(tag, "exec_sel",    {12'b0, bus.exec_sel},    {12'b0, e.sel});
`ifdef HAZARD_PERF_CNT_EN
    checkValue(tag, "lu_stall_cnt",  bus.lu_stall_cnt,  e.lu);
    checkValue(tag, "mem_stall_cnt", bus.mem_stall_cnt, e.mc);
`endif
  endtask

  // One cycle: drive, check mid-cycle, then let DUT and model both clock.
  task automatic runVector(input vec_t v, input bit use_table);
    vec_t e;
    applyStimulus(v);
    @(negedge clk);
    e = model_expect(v);
    checkOutput(v.name, use_table ? v : e);
    @(posedge clk);
    model_advance(v, e);
    #1;
  endtask

  function automatic vec_t rand_vec(input int idx, input bit busy);
    vec_t v;
    v = mk($sformatf("rand%0d", idx), ($urandom_range(0, 59) == 0), 1'($urandom),
           3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom),
           3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 3)), 1'($urandom),
           3'($urandom_range(0, 3)), 1'($urandom),
           busy, 0, 0, 0, 0, 0, 0);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   busy_left;
    tests_run    = 0;
    tests_failed = 0;

    //            name           r  vl s0 s1 used   exr w mr memr w wbr w busy st bb fz sel      lu mc
    tbl.push_back(mk("rst_hold",    1, 1, 3, 5, 2'b11, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("fwd_ex_mem",  0, 1, 3, 5, 2'b11, 3, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("ex_over_mem", 0, 1, 4, 6, 2'b11, 4, 1, 0, 4, 1, 6, 1, 0, 0, 0, 0, 4'b1001, 0, 0));
    tbl.push_back(mk("lu_detect",   0, 1, 2, 7, 2'b01, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1101, 0, 0));
    tbl.push_back(mk("lu_to_mem",   0, 1, 2, 7, 2'b01, 1, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("quiet",       0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 0));
    tbl.push_back(mk("lu_unused",   0, 1, 2, 0, 2'b00, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("lu_invalid",  0, 0, 2, 0, 2'b01, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("fwd_setup",   0, 1, 3, 5, 2'b11, 3, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("busy_1",      0, 1, 2, 5, 2'b01, 2, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 4'b1001, 1, 0));
    tbl.push_back(mk("busy_2",      0, 1, 2, 5, 2'b01, 2, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 4'b1001, 1, 1));
    tbl.push_back(mk("busy_3",      0, 1, 2, 5, 2'b01, 2, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 4'b1001, 1, 2));
    tbl.push_back(mk("busy_4",      0, 1, 2, 5, 2'b01, 2, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 4'b1001, 1, 3));
    tbl.push_back(mk("busy_end",    0, 1, 2, 5, 2'b01, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1001, 1, 4));
    tbl.push_back(mk("quiet2",      0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 4));
    tbl.push_back(mk("lu_again",    0, 1, 2, 7, 2'b01, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 1, 4));
    tbl.push_back(mk("rst_in_lu",   1, 1, 2, 7, 2'b01, 2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2, 4));
    tbl.push_back(mk("lu_redetect", 0, 1, 2, 7, 2'b01, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("quiet3",      0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("wb_only",     0, 1, 6, 1, 2'b11, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("wb_observe",  0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 1, 0));

    // Start from a clean reset so both DUT and model agree on every register.
    m_sel = '0; m_prev_frz = 0; m_prev_bub = 0; m_lu = 0; m_mc = 0;
    applyStimulus(tbl[0]);
    @(posedge clk);
    model_advance(tbl[0], model_expect(tbl[0]));
    #1;

    foreach (tbl[i]) runVector(tbl[i], 1'b1);

    busy_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 5);
      v = rand_vec(n, busy_left > 0);
      if (busy_left > 0) busy_left--;
      runVector(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
